// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus an iterative multiply/divide unit with
// HI/LO result registers. ALU ops (0-11) return one cycle after accept;
// MULT/MULTU/DIV/DIVU (12-15) take WIDTH iteration cycles, then a DONE cycle.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  input  logic             care,
  output logic [WIDTH-1:0] C,
  output logic             ov,
  output logic             valid,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MSB  = WIDTH - 1;
  localparam int HALF = WIDTH / 2;
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_LUI  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Architectural outputs
  logic [WIDTH-1:0] c_q, c_d;
  logic             ov_q, ov_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Iteration state: opnd holds the multiplicand or divisor magnitude,
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;

  // Combinational helpers
  logic [WIDTH-1:0]   add_res, sub_res, alu_res;
  logic               alu_ov;
  logic               op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_fin;
  logic [WIDTH:0]     rem_shift;
  logic               rem_fits;
  logic [WIDTH-1:0]   rem_sub, rem_new;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   div_quo, div_rem, quo_fin, rem_fin;

  assign op_signed = ~op[0];

  // Single-cycle ALU result and signed-overflow detection for ADD/SUB
  always_comb begin
    add_res = A + B;
    sub_res = A - B;
    alu_res = '0;
    alu_ov  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_res;
        alu_ov  = care & (A[MSB] == B[MSB]) & (add_res[MSB] != A[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ov  = care & (A[MSB] != B[MSB]) & (sub_res[MSB] != A[MSB]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_LUI:  alu_res = {B[HALF-1:0], {HALF{1'b0}}};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  alu_res = B << shamt;
      OP_SRL:  alu_res = B >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(B) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Magnitudes of the operands for the signed multiply/divide variants;
  // the most-negative value maps onto itself, which is correct as unsigned.
  always_comb begin
    a_mag = A[MSB] ? -A : A;
    b_mag = B[MSB] ? -B : B;
  end

  // One shift-add multiply step plus the sign-corrected final product
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    mul_fin  = neg_q ? -mul_next : mul_next;
  end

  // One restoring-division step plus sign correction of quotient/remainder.
  // The remainder is always below the divisor, so the W-bit subtraction is
  // exact whenever the shifted remainder fits.
  always_comb begin
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_fits  = (rem_shift >= {1'b0, opnd_q});
    rem_sub   = rem_shift[WIDTH-1:0] - opnd_q;
    rem_new   = rem_fits ? rem_sub : rem_shift[WIDTH-1:0];
    div_next  = {rem_new, acc_q[WIDTH-2:0], rem_fits};
    div_quo   = div_next[WIDTH-1:0];
    div_rem   = div_next[2*WIDTH-1:WIDTH];
    quo_fin   = neg_q ? -div_quo : div_quo;
    rem_fin   = rem_neg_q ? -div_rem : div_rem;
  end

  // Next-state and datapath update: accept, iterate, publish in DONE
  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    ov_d       = ov_q;
    valid_d    = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    dbz_d      = dbz_q;
    dividend_d = dividend_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (op[3:2] != 2'b11) begin
            c_d     = alu_res;
            ov_d    = alu_ov;
            valid_d = 1'b1;
          end else if (op[1] == 1'b0) begin
            state_d    = S_MUL;
            cnt_d      = '0;
            opnd_d     = op_signed ? a_mag : A;
            acc_d      = {{WIDTH{1'b0}}, (op_signed ? b_mag : B)};
            neg_d      = op_signed & (A[MSB] ^ B[MSB]);
            rem_neg_d  = 1'b0;
            dbz_d      = 1'b0;
            dividend_d = A;
          end else begin
            state_d    = S_DIV;
            cnt_d      = '0;
            opnd_d     = op_signed ? b_mag : B;
            acc_d      = {{WIDTH{1'b0}}, (op_signed ? a_mag : A)};
            neg_d      = op_signed & (A[MSB] ^ B[MSB]);
            rem_neg_d  = op_signed & A[MSB];
            dbz_d      = (B == '0);
            dividend_d = A;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          hi_d    = mul_fin[2*WIDTH-1:WIDTH];
          lo_d    = mul_fin[WIDTH-1:0];
          c_d     = mul_fin[WIDTH-1:0];
          ov_d    = 1'b0;
          valid_d = 1'b1;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          ov_d    = 1'b0;
          valid_d = 1'b1;
          if (dbz_q) begin
            hi_d = dividend_q;
            lo_d = '1;
            c_d  = '1;
          end else begin
            hi_d = rem_fin;
            lo_d = quo_fin;
            c_d  = quo_fin;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      ov_q       <= 1'b0;
      valid_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_q      <= 1'b0;
      dividend_q <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      ov_q       <= ov_d;
      valid_q    <= valid_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      dbz_q      <= dbz_d;
      dividend_q <= dividend_d;
    end
  end

  assign C     = c_q;
  assign ov    = ov_q;
  assign valid = valid_q;
  assign busy  = (state_q == S_MUL) || (state_q == S_DIV);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
